// File: rtl/bit_packer.sv
// Packs variable-length fields MSB-first into aligned 64-bit words, with flush padding and end-of-frame drain.
// Defining BIT_PACKER_STATS_EN adds a per-frame byte counter on total_bytes.
module bit_packer #(
    parameter int   FLUSH_ALIGN = 8,
    parameter logic PAD_BIT     = 1'b0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        input_enable,
    input  logic [63:0] val,
    input  logic [63:0] size_of_bit,
    input  logic        flush_bit,
    input  logic        eof,
    output logic        out_valid,
    output logic [63:0] out_data,
    output logic [3:0]  out_nbytes,
    output logic        out_last,
    output logic        busy,
    output logic        err_size
`ifdef BIT_PACKER_STATS_EN
    ,
    output logic [31:0] total_bytes
`endif
);

    typedef enum logic {RUN, DRAIN} state_t;

    localparam logic [127:0] ONES128    = {128{1'b1}};
    localparam logic [63:0]  ONES64     = {64{1'b1}};
    localparam logic [7:0]   ALIGN_M1   = 8'(FLUSH_ALIGN - 1);
    localparam logic [7:0]   ALIGN_MASK = ~ALIGN_M1;

    state_t       state_q;
    logic [127:0] acc_q;      // valid bits are left-justified; bits below count_q stay zero
    logic [6:0]   count_q;

    logic         size_bad;
    logic [6:0]   n;
    logic [63:0]  field;
    logic [7:0]   cnt_app;
    logic [7:0]   cnt_al;
    logic [7:0]   cnt_fl;
    logic [7:0]   cnt_rem;
    logic [7:0]   sh;
    logic [127:0] ext;
    logic [127:0] padmask;
    logic [127:0] acc_app;
    logic [127:0] acc_fl;
    logic         emit_run;
    logic [63:0]  drain_data;
    logic [7:0]   drain_sum;
    logic [3:0]   drain_nbytes;
    logic         emit_any;
    logic [3:0]   emit_nbytes;

    always_comb begin
        size_bad = input_enable && (size_of_bit > 64'd64);
        n        = 7'd0;
        if (input_enable)
            n = size_bad ? 7'd64 : size_of_bit[6:0];
        field    = (n == 7'd64) ? val : (val & ((64'd1 << n) - 64'd1));

        // Place the field directly below the bits already held.
        cnt_app  = {1'b0, count_q} + {1'b0, n};
        sh       = 8'd128 - cnt_app;
        ext      = {64'd0, field} << sh;
        acc_app  = acc_q | ext;

        cnt_al   = (cnt_app + ALIGN_M1) & ALIGN_MASK;
        cnt_fl   = flush_bit ? cnt_al : cnt_app;
        padmask  = (ONES128 >> cnt_app) & ~(ONES128 >> cnt_fl);
        acc_fl   = PAD_BIT ? (acc_app | padmask) : acc_app;

        emit_run = (cnt_fl >= 8'd64);
        cnt_rem  = emit_run ? (cnt_fl - 8'd64) : cnt_fl;

        drain_data   = acc_q[127:64] | (PAD_BIT ? (ONES64 >> count_q) : 64'd0);
        drain_sum    = {1'b0, count_q} + 8'd7;
        drain_nbytes = drain_sum[6:3];

        emit_any    = (state_q == RUN) ? emit_run : (count_q != 7'd0);
        emit_nbytes = (state_q == RUN) ? 4'd8 : drain_nbytes;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RUN;
            acc_q      <= '0;
            count_q    <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_nbytes <= '0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            err_size   <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout; every register here sees the pre-edge values of its peers.
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            case (state_q)
                RUN: begin
                    if (size_bad)
                        err_size <= 1'b1;
                    if (emit_run) begin
                        out_valid  <= 1'b1;
                        out_data   <= acc_fl[127:64];
                        out_nbytes <= 4'd8;
                        acc_q      <= acc_fl << 64;
                    end else begin
                        acc_q      <= acc_fl;
                    end
                    count_q <= cnt_rem[6:0];
                    if (eof) begin
                        // An empty remainder needs no drain; tag the word just emitted instead.
                        if (cnt_rem == 8'd0) begin
                            out_last <= emit_run;
                        end else begin
                            state_q <= DRAIN;
                            busy    <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (count_q != 7'd0) begin
                        out_valid  <= 1'b1;
                        out_data   <= drain_data;
                        out_nbytes <= drain_nbytes;
                        out_last   <= 1'b1;
                    end
                    acc_q   <= '0;
                    count_q <= '0;
                    busy    <= 1'b0;
                    state_q <= RUN;
                end
                default: state_q <= RUN;
            endcase
        end
    end

`ifdef BIT_PACKER_STATS_EN
    logic [31:0] total_q;

    // Counts up with each word and restarts after the frame's last word has been shown for a cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            total_q <= '0;
        else
            total_q <= (out_last ? 32'd0 : total_q) + (emit_any ? 32'(emit_nbytes) : 32'd0);
    end

    assign total_bytes = total_q;
`else
    logic unused_stats;
    assign unused_stats = emit_any ^ (^emit_nbytes);
`endif

endmodule
